// File: rtl/stage_control.sv
// stage_control: multi-cycle instruction sequencer for the picoMips core.
// Latches the instruction, steps it through NSTAGE stages and holds PC on wait.
module stage_control #(
    parameter int IW        = 13,
    parameter int DW        = 8,
    parameter int IMMW      = 6,
    parameter int NSTAGE    = 4,
    parameter int ACC_STAGE = 2,
    parameter int DEB       = 2,
    localparam int SW       = $clog2(NSTAGE),
    localparam int CW       = $clog2(DEB + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [IW-1:0] instr,
    input  logic          handshake,
    output logic [DW-1:0] imm,
    output logic [SW-1:0] stage,
    output logic          pc_inc,
    output logic          waiting,
    output logic          reg_we,
    output logic          acc_we,
    output logic          reg_addr,
    output logic          use_a,
    output logic          sel_sw,
    output logic          sel_imm,
    output logic          use_mul,
    output logic          sel_reg
);

    typedef enum logic {
        S_EXEC,
        S_WAIT
    } state_t;

    state_t        state;
    logic [IW-1:0] ir;
    logic [CW-1:0] cnt;

    logic [6:0] func;
    logic       is_wait;
    logic       is_rw;
    logic       arg;
    logic       last;
    logic       in_exec;
    logic       released;
    logic       deb_done;

    assign func     = ir[IW-1 -: 7];
    assign is_rw    = func[4];
    assign is_wait  = func[5];
    assign arg      = ir[0];
    assign last     = (stage == SW'(NSTAGE - 1));
    assign in_exec  = (state == S_EXEC);
    assign released = (handshake != arg);
    assign deb_done = released && (cnt == CW'(DEB - 1));

    assign use_a    = func[0];
    assign sel_sw   = func[1];
    assign sel_imm  = func[2];
    assign use_mul  = func[3];
    assign sel_reg  = func[6];
    assign reg_addr = ir[0];
    assign imm      = DW'($signed(ir[IMMW-1:0]));
    assign waiting  = (state == S_WAIT);

    // Strobes are masked during reset so an abandoned instruction has no effect.
    assign pc_inc = !reset &&
                    ((in_exec && last && !is_wait) || (!in_exec && deb_done));
    assign acc_we = !reset && in_exec && (stage == SW'(ACC_STAGE))
                    && !is_rw && !is_wait;
    assign reg_we = !reset && in_exec && last && is_rw && !is_wait;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_EXEC;
            stage <= '0;
            ir    <= '0;
            cnt   <= '0;
        end else begin
            unique case (state)
                S_EXEC: begin
                    if (stage == '0) begin
                        ir <= instr;
                    end
                    if (last) begin
                        cnt <= '0;
                        if (is_wait) begin
                            state <= S_WAIT;
                        end else begin
                            stage <= '0;
                        end
                    end else begin
                        stage <= stage + SW'(1);
                    end
                end
                S_WAIT: begin
                    // Any return to arg restarts the debounce window.
                    if (!released) begin
                        cnt <= '0;
                    end else if (deb_done) begin
                        cnt   <= '0;
                        stage <= '0;
                        state <= S_EXEC;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: begin
                    state <= S_EXEC;
                    stage <= '0;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage_control.sv
// Scoreboard bench for stage_control: random and directed instruction streams
// checked against a per-instruction timing/decode model.
module tb_stage_control;

    localparam int IW        = 13;
    localparam int DW        = 8;
    localparam int IMMW      = 6;
    localparam int NSTAGE    = 4;
    localparam int ACC_STAGE = 2;
    localparam int DEB       = 2;
    localparam int SW        = $clog2(NSTAGE);
    localparam int LW        = 6 + DW;

    logic          clk;
    logic          reset;
    logic [IW-1:0] instr;
    logic          handshake;
    logic [DW-1:0] imm;
    logic [SW-1:0] stage;
    logic          pc_inc, waiting, reg_we, acc_we;
    logic          reg_addr, use_a, sel_sw, sel_imm, use_mul, sel_reg;

    stage_control #(
        .IW(IW), .DW(DW), .IMMW(IMMW), .NSTAGE(NSTAGE),
        .ACC_STAGE(ACC_STAGE), .DEB(DEB)
    ) dut (
        .clk(clk), .reset(reset), .instr(instr), .handshake(handshake),
        .imm(imm), .stage(stage), .pc_inc(pc_inc), .waiting(waiting),
        .reg_we(reg_we), .acc_we(acc_we), .reg_addr(reg_addr),
        .use_a(use_a), .sel_sw(sel_sw), .sel_imm(sel_imm),
        .use_mul(use_mul), .sel_reg(sel_reg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int len;
        int acc_n;
        int acc_pos;
        int reg_n;
        int reg_pos;
        int wait_n;
        logic [LW-1:0] lv;
    } exp_t;

    exp_t sb[$];
    bit   hsq[$];
    int   n_chk = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: wait length is the first window of DEB consecutive releases.
    function automatic exp_t model(input logic [IW-1:0] ins);
        exp_t e;
        logic [6:0] f;
        int v, nw;
        bit ok;
        f = ins[IW-1 -: 7];
        nw = 0;
        if (f[5]) begin
            for (int i = DEB - 1; i < hsq.size(); i++) begin
                ok = 1'b1;
                for (int j = i - DEB + 1; j <= i; j++)
                    if (hsq[j] == ins[0]) ok = 1'b0;
                if (ok && nw == 0) nw = i + 1;
            end
        end
        v = int'(ins[IMMW-1:0]);
        if (v >= (1 << (IMMW - 1))) v = v - (1 << IMMW);
        e.wait_n  = nw;
        e.len     = NSTAGE + nw;
        e.acc_n   = (!f[4] && !f[5]) ? 1 : 0;
        e.acc_pos = (e.acc_n == 1) ? ACC_STAGE : -1;
        e.reg_n   = (f[4] && !f[5]) ? 1 : 0;
        e.reg_pos = (e.reg_n == 1) ? NSTAGE - 1 : -1;
        e.lv      = {f[0], f[1], f[2], f[3], f[6], ins[0], DW'(v)};
        return e;
    endfunction

    int pos = 0, a_n = 0, a_pos = -1, r_n = 0, r_pos = -1, w_n = 0;
    logic [LW-1:0] lv_cap = '0;
    exp_t em;

    always @(negedge clk) begin
        if (mon_en) begin
            if (reset) begin
                chk("rst_strobes", {pc_inc, acc_we, reg_we}, 0);
                pos = 0; a_n = 0; a_pos = -1; r_n = 0; r_pos = -1; w_n = 0;
            end else begin
                chk("stage", stage, (pos < NSTAGE) ? pos : NSTAGE - 1);
                if (acc_we) begin a_n++; a_pos = pos; end
                if (reg_we) begin r_n++; r_pos = pos; end
                if (waiting) w_n++;
                if (pos == 1)
                    lv_cap = {use_a, sel_sw, sel_imm, use_mul, sel_reg,
                              reg_addr, imm};
                if (pc_inc) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_pc_inc", 1, 0);
                    end else begin
                        em = sb.pop_front();
                        chk("instr_len", pos + 1, em.len);
                        chk("acc_count", a_n, em.acc_n);
                        chk("acc_stage", a_pos, em.acc_pos);
                        chk("reg_count", r_n, em.reg_n);
                        chk("reg_stage", r_pos, em.reg_pos);
                        chk("wait_cycles", w_n, em.wait_n);
                        chk("decode", lv_cap, em.lv);
                    end
                    pos = 0; a_n = 0; a_pos = -1; r_n = 0; r_pos = -1; w_n = 0;
                end else begin
                    pos++;
                    if (pos == 200) chk("pc_inc_timeout", pos, 0);
                end
            end
        end
    end

    task automatic cyc(input logic [IW-1:0] ins, input logic hs);
        instr     = ins;
        handshake = hs;
        @(posedge clk);
        #1;
    endtask

    task automatic run_instr(input logic [IW-1:0] ins);
        exp_t e;
        e = model(ins);
        sb.push_back(e);
        cyc(ins, 1'($urandom));
        for (int k = 1; k < NSTAGE; k++) cyc(IW'($urandom), 1'($urandom));
        for (int k = 0; k < e.wait_n; k++) cyc(IW'($urandom), hsq[k]);
    endtask

    function automatic logic [IW-1:0] mk(input logic [6:0] f,
                                         input logic [IMMW-1:0] im);
        logic [IW-1:0] r;
        r = IW'($urandom);
        r[IW-1 -: 7] = f;
        r[IMMW-1:0] = im;
        return r;
    endfunction

    task automatic gen_hs(input logic a);
        int run;
        bit b;
        hsq.delete();
        run = 0;
        while (run < DEB) begin
            b = ($urandom_range(0, 9) < 7) ? !a : a;
            if (hsq.size() > 30) b = !a;
            hsq.push_back(b);
            run = (b != a) ? run + 1 : 0;
        end
    endtask

    logic [IW-1:0] ins;
    logic [6:0]    f;
    logic          a;

    initial begin
        reset = 1'b1;
        instr = '0;
        handshake = 1'b0;
        mon_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            cyc(IW'($urandom), k[0]);
            chk("rst_outputs", {imm, stage, pc_inc, waiting, reg_we, acc_we,
                reg_addr, use_a, sel_sw, sel_imm, use_mul, sel_reg}, 0);
        end
        reset = 1'b0;

        for (int k = 0; k < 5; k++)
            run_instr(mk(7'b0000101, IMMW'($urandom)));
        run_instr(mk(7'b0010000, IMMW'($urandom) | IMMW'(1)));
        run_instr(mk(7'b0000000, 6'b100000));
        run_instr(mk(7'b1001011, 6'b011111));

        hsq.delete();
        for (int k = 0; k < 10; k++) hsq.push_back(1'b1);
        for (int k = 0; k < DEB; k++) hsq.push_back(1'b0);
        run_instr(mk(7'b0100000, 6'b000001));

        hsq.delete();
        hsq.push_back(1'b0);
        hsq.push_back(1'b1);
        for (int k = 0; k < DEB; k++) hsq.push_back(1'b0);
        run_instr(mk(7'b0100000, 6'b000001));

        // Reset while the debounce is one release short of exiting.
        a = 1'($urandom);
        ins = mk(7'b0100000, {5'($urandom), a});
        cyc(ins, 1'($urandom));
        for (int k = 1; k < NSTAGE; k++) cyc(IW'($urandom), 1'($urandom));
        for (int k = 0; k < 3; k++) cyc(IW'($urandom), a);
        for (int k = 0; k < DEB - 1; k++) cyc(IW'($urandom), !a);
        chk("wait_before_rst", waiting, 1);
        handshake = !a;
        reset = 1'b1;
        #3;
        chk("rst_wait_pc_inc", pc_inc, 0);
        chk("rst_wait_waiting", waiting, 1);
        @(posedge clk);
        #1;
        chk("post_rst_waiting", waiting, 0);
        chk("post_rst_stage", stage, 0);
        reset = 1'b0;

        for (int k = 0; k < 40; k++) begin
            f = 7'($urandom);
            if ($urandom_range(0, 3) == 0) begin
                f[5] = 1'b1;
                ins = mk(f, IMMW'($urandom));
                gen_hs(ins[0]);
            end else begin
                f[5] = 1'b0;
                ins = mk(f, IMMW'($urandom));
            end
            run_instr(ins);
        end

        cyc(IW'($urandom), 1'($urandom));
        cyc(IW'($urandom), 1'($urandom));
        mon_en = 1'b0;
        chk("scoreboard_empty", sb.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
